// File: rtl/agc_sequencer.sv
// agc_sequencer: Wishbone initiator that runs the AGC loop (tick, poll, read, calc, write, apply).
// Define AGC_SEQ_OFFSET_EN to include the gt/lt offset loop; the default build adjusts scale only.
module agc_sequencer #(
  parameter logic [21:0] BASE_ADDR       = 22'h0,
  parameter logic [23:0] SQ_TARGET       = 24'd4194304,
  parameter logic [23:0] SQ_HYST         = 24'd262144,
  parameter logic [16:0] SCALE_STEP      = 17'd256,
  parameter logic [16:0] SCALE_INIT      = 17'h10000,
  parameter logic [7:0]  OFFSET_INIT     = 8'h00,
  parameter logic [20:0] OFFSET_DEADBAND = 21'd64,
  parameter logic [15:0] POLL_LIMIT      = 16'd1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic        start_i,
  input  logic        continuous_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [16:0] scale_o,
  output logic [7:0]  offset_o,
  output logic [23:0] sq_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [21:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);
  typedef enum logic [3:0] {
    S_IDLE, S_TICK, S_POLL, S_RD_SQ, S_RD_GT, S_RD_LT,
    S_CALC, S_WR_SCALE, S_WR_OFF, S_WR_CTRL, S_DONE
  } state_t;

  localparam logic [24:0] SQ_HI = {1'b0, SQ_TARGET} + {1'b0, SQ_HYST};
  localparam logic [24:0] SQ_LO = (SQ_HYST > SQ_TARGET) ? 25'd0 : ({1'b0, SQ_TARGET} - {1'b0, SQ_HYST});
`ifdef AGC_SEQ_OFFSET_EN
  localparam logic [31:0] CTRL_APPLY = 32'h0000_0700;
`else
  localparam logic [31:0] CTRL_APPLY = 32'h0000_0500;
`endif

  state_t      r_state;
  logic        r_cyc, r_we, r_busy, r_done, r_err, r_first;
  logic [21:0] r_adr;
  logic [31:0] r_dat;
  logic [15:0] r_poll_cnt;
  logic [23:0] r_sq;
  logic [16:0] r_scale, r_scale_nxt;
  logic        w_bus_err, w_we, w_unused_ok;
  logic [21:0] w_adr;
  logic [31:0] w_dat;
  logic [17:0] w_scale_sum;
  logic [16:0] w_scale_calc;

  assign w_bus_err   = wb_err_i | wb_rty_i;
  assign w_unused_ok = ^wb_dat_i[31:24];

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign err_o    = r_err;
  assign scale_o  = r_scale;
  assign sq_o     = r_sq;
  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_cyc;
  assign wb_we_o  = r_we;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;
  assign wb_sel_o = 4'hF;

`ifdef AGC_SEQ_OFFSET_EN
  localparam logic signed [21:0] DEADBAND_S = $signed({1'b0, OFFSET_DEADBAND});
  logic [20:0]        r_gt, r_lt;
  logic [7:0]         r_offset, r_off_nxt, w_off_calc;
  logic signed [21:0] w_diff;

  assign offset_o = r_offset;

  // Offset walks opposite to the gt/lt imbalance and saturates at -128/+127.
  always_comb begin
    w_diff     = $signed({1'b0, r_gt}) - $signed({1'b0, r_lt});
    w_off_calc = r_offset;
    if (w_diff > DEADBAND_S && r_offset != 8'h80)
      w_off_calc = r_offset - 8'd1;
    else if (w_diff < -DEADBAND_S && r_offset != 8'h7F)
      w_off_calc = r_offset + 8'd1;
  end
`else
  assign offset_o = OFFSET_INIT;
`endif

  always_comb begin
    w_scale_sum  = {1'b0, r_scale} + {1'b0, SCALE_STEP};
    w_scale_calc = r_scale;
    if ({1'b0, r_sq} > SQ_HI)
      w_scale_calc = (r_scale > SCALE_STEP) ? (r_scale - SCALE_STEP) : 17'd0;
    else if ({1'b0, r_sq} < SQ_LO)
      w_scale_calc = w_scale_sum[17] ? 17'h1FFFF : w_scale_sum[16:0];
  end

  always_comb begin
    w_we  = 1'b0;
    w_adr = BASE_ADDR;
    w_dat = 32'd0;
    case (r_state)
      S_TICK:     begin w_we = 1'b1; w_dat = 32'h1; end
      S_RD_SQ:    w_adr = BASE_ADDR + 22'h04;
      S_RD_GT:    w_adr = BASE_ADDR + 22'h08;
      S_RD_LT:    w_adr = BASE_ADDR + 22'h0C;
      S_WR_SCALE: begin w_we = 1'b1; w_adr = BASE_ADDR + 22'h10; w_dat = {15'd0, r_scale_nxt}; end
`ifdef AGC_SEQ_OFFSET_EN
      S_WR_OFF:   begin w_we = 1'b1; w_adr = BASE_ADDR + 22'h14; w_dat = {24'd0, r_off_nxt}; end
`endif
      S_WR_CTRL:  begin w_we = 1'b1; w_dat = CTRL_APPLY; end
      default:    ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_state     <= S_IDLE;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_first     <= 1'b1;
      r_poll_cnt  <= '0;
      r_sq        <= '0;
      r_scale     <= SCALE_INIT;
      r_scale_nxt <= SCALE_INIT;
`ifdef AGC_SEQ_OFFSET_EN
      r_gt        <= '0;
      r_lt        <= '0;
      r_offset    <= OFFSET_INIT;
      r_off_nxt   <= OFFSET_INIT;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start_i) begin
          r_err   <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= S_TICK;
        end
        S_CALC: begin
          r_first     <= 1'b0;
          r_scale_nxt <= r_first ? SCALE_INIT : w_scale_calc;
`ifdef AGC_SEQ_OFFSET_EN
          r_off_nxt   <= r_first ? OFFSET_INIT : w_off_calc;
`endif
          r_state     <= S_WR_SCALE;
        end
        S_DONE: if (continuous_i) r_state <= S_TICK;
        else begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          // First cycle of every bus state is idle; the request is issued on the next.
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_we  <= w_we;
            r_adr <= w_adr;
            r_dat <= w_dat;
          end else if (w_bus_err) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (wb_ack_i) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            case (r_state)
              S_TICK: begin
                r_poll_cnt <= POLL_LIMIT;
                r_state    <= S_POLL;
              end
              S_POLL: begin
                if (wb_dat_i[1]) r_state <= S_RD_SQ;
                else if (r_poll_cnt <= 16'd1) begin
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                end else r_poll_cnt <= r_poll_cnt - 16'd1;
              end
              S_RD_SQ: begin
                r_sq <= wb_dat_i[23:0];
`ifdef AGC_SEQ_OFFSET_EN
                r_state <= S_RD_GT;
`else
                r_state <= S_CALC;
`endif
              end
`ifdef AGC_SEQ_OFFSET_EN
              S_RD_GT: begin r_gt <= wb_dat_i[20:0]; r_state <= S_RD_LT; end
              S_RD_LT: begin r_lt <= wb_dat_i[20:0]; r_state <= S_CALC; end
              S_WR_OFF: begin r_offset <= r_off_nxt; r_state <= S_WR_CTRL; end
`endif
              S_WR_SCALE: begin
                r_scale <= r_scale_nxt;
`ifdef AGC_SEQ_OFFSET_EN
                r_state <= S_WR_OFF;
`else
                r_state <= S_WR_CTRL;
`endif
              end
              S_WR_CTRL: begin r_done <= 1'b1; r_state <= S_DONE; end
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_agc_sequencer.sv
// tb_agc_sequencer: directed bench with a simple AGC register target model and a bus log.
module tb_agc_sequencer;
`ifdef AGC_SEQ_OFFSET_EN
  localparam bit OFF_EN = 1'b1;
`else
  localparam bit OFF_EN = 1'b0;
`endif
  localparam logic [31:0] CTRL_EXP = OFF_EN ? 32'h700 : 32'h500;

  logic        wb_clk_i = 1'b0, wb_rstn_i = 1'b0;
  logic        start_i = 1'b0, continuous_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic [16:0] scale_o;
  logic [7:0]  offset_o;
  logic [23:0] sq_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [21:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

  int          n_chk = 0, n_err = 0, n_done = 0;
  int          poll_n = 0, done_on = 3;
  logic [23:0] tgt_sq = '0;
  logic [20:0] tgt_gt = '0, tgt_lt = '0;
  bit          inj_err = 1'b0;
  logic [21:0] err_adr = '0;
  logic [54:0] log_q[$];

  agc_sequencer dut (
    .wb_clk_i(wb_clk_i), .wb_rstn_i(wb_rstn_i), .start_i(start_i), .continuous_i(continuous_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .scale_o(scale_o), .offset_o(offset_o),
    .sq_o(sq_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Target model: answers each request on the falling edge after it appears.
  always @(negedge wb_clk_i) begin
    if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
      if (inj_err && wb_adr_o == err_adr) wb_err_i = 1'b1;
      else begin
        wb_ack_i = 1'b1;
        if (wb_we_o) begin
          if (wb_adr_o == 22'h0 && wb_dat_o == 32'h1) poll_n = 0;
          wb_dat_i = '0;
        end else begin
          case (wb_adr_o)
            22'h00: begin
              poll_n++;
              wb_dat_i = (done_on != 0 && poll_n >= done_on) ? 32'h2 : 32'h0;
            end
            22'h04:  wb_dat_i = {8'hA5, tgt_sq};
            22'h08:  wb_dat_i = {11'h5A5, tgt_gt};
            22'h0C:  wb_dat_i = {11'h5A5, tgt_lt};
            default: wb_dat_i = 32'hDEAD_BEEF;
          endcase
        end
      end
    end else begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
    end
  end

  always @(posedge wb_clk_i) begin
    if (wb_cyc_o && wb_stb_o && wb_ack_i)
      log_q.push_back({wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : 32'h0});
    if (done_o) n_done++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cnt_acc(input bit we, input logic [21:0] adr);
    int n = 0;
    foreach (log_q[i]) if (log_q[i][54] == we && log_q[i][53:32] == adr) n++;
    return n;
  endfunction

  function automatic logic [31:0] last_wr(input logic [21:0] adr);
    logic [31:0] v = 32'hFFFF_FFFF;
    foreach (log_q[i]) if (log_q[i][54] && log_q[i][53:32] == adr) v = log_q[i][31:0];
    return v;
  endfunction

  task automatic pulse_start();
    @(negedge wb_clk_i); start_i = 1'b1;
    @(negedge wb_clk_i); start_i = 1'b0;
  endtask

  task automatic run_iter(input string tag);
    int k = 0;
    pulse_start();
    while (busy_o && k < 5000) begin @(negedge wb_clk_i); k++; end
    chk({tag, "_finish"}, busy_o, 1'b0);
  endtask

  task automatic expect_iter(input string tag, input int polls, input logic [16:0] sc, input logic [7:0] of);
    logic [54:0] e[$];
    e.push_back({1'b1, 22'h00, 32'h1});
    for (int i = 0; i < polls; i++) e.push_back({1'b0, 22'h00, 32'h0});
    e.push_back({1'b0, 22'h04, 32'h0});
    if (OFF_EN) begin
      e.push_back({1'b0, 22'h08, 32'h0});
      e.push_back({1'b0, 22'h0C, 32'h0});
    end
    e.push_back({1'b1, 22'h10, 15'h0, sc});
    if (OFF_EN) e.push_back({1'b1, 22'h14, 24'h0, of});
    e.push_back({1'b1, 22'h00, CTRL_EXP});
    chk({tag, "_ntx"}, log_q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      chk($sformatf("%s_tx%0d", tag, i), (i < log_q.size()) ? log_q[i] : 55'h0, e[i]);
    chk({tag, "_scale_o"}, scale_o, sc);
    chk({tag, "_offset_o"}, offset_o, OFF_EN ? of : 8'h00);
  endtask

  task automatic run_cont(input string tag, input int n);
    int d = 0, gaps = 0, cyc = 0, late = 0;
    @(negedge wb_clk_i); continuous_i = 1'b1; start_i = 1'b1;
    @(negedge wb_clk_i);
    while (d < n && cyc < n * 100) begin
      start_i = (cyc == 7);
      if (!busy_o) gaps++;
      if (done_o) begin
        d++;
        if (d == n) begin continuous_i = 1'b0; start_i = 1'b1; end
      end
      if (d < n) begin @(negedge wb_clk_i); cyc++; end
    end
    @(negedge wb_clk_i); start_i = 1'b0; continuous_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy_o) late++;
      @(negedge wb_clk_i);
    end
    chk({tag, "_iters"}, d, n);
    chk({tag, "_busy_gap"}, gaps, 0);
    chk({tag, "_idle_after"}, late, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int d0;
    repeat (3) @(negedge wb_clk_i);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_we", wb_we_o, 1'b0);
    chk("rst_adr", wb_adr_o, 22'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_sel", wb_sel_o, 4'hF);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_scale", scale_o, 17'h10000);
    chk("rst_offset", offset_o, 8'h00);
    chk("rst_sq", sq_o, 24'h0);
    wb_rstn_i = 1'b1;

    // First iteration: done on third poll, initial values written
    done_on = 3; tgt_sq = 24'h123456; tgt_gt = 21'd5; tgt_lt = 21'd900;
    log_q.delete(); d0 = n_done;
    run_iter("it1");
    expect_iter("it1", 3, 17'h10000, 8'h00);
    chk("it1_done_cnt", n_done - d0, 1);
    chk("it1_sq_o", sq_o, 24'h123456);

    // Loud input and gt > lt: scale down one step, offset -1
    done_on = 1; tgt_sq = 24'h600000; tgt_gt = 21'd1000; tgt_lt = 21'd100;
    log_q.delete();
    run_iter("it2");
    expect_iter("it2", 1, 17'h0FF00, 8'hFF);
    chk("it2_sq_o", sq_o, 24'h600000);

    // In-band level, persistent gt > lt: offset walks to -128 and holds
    tgt_sq = 24'h400000; tgt_gt = 21'd1000; tgt_lt = 21'd0;
    log_q.delete();
    run_cont("offlo", 130);
    chk("offlo_offset", offset_o, OFF_EN ? 8'h80 : 8'h00);
    chk("offlo_scale", scale_o, 17'h0FF00);
    chk("offlo_nwr14", cnt_acc(1'b1, 22'h14), OFF_EN ? 130 : 0);

    // Quiet input and lt > gt: scale up, offset climbs off the floor
    tgt_sq = 24'h0; tgt_gt = 21'd0; tgt_lt = 21'd1000;
    log_q.delete();
    run_iter("it4");
    expect_iter("it4", 1, 17'h10000, 8'h81);

    log_q.delete();
    run_cont("sat", 260);
    chk("sat_scale", scale_o, 17'h1FFFF);
    chk("sat_scale_wr", last_wr(22'h10), 32'h1FFFF);
    chk("sat_offset", offset_o, OFF_EN ? 8'h7F : 8'h00);

    // Done never reported: timeout after POLL_LIMIT reads, no writes
    done_on = 0; log_q.delete(); d0 = n_done;
    run_iter("tmo");
    chk("tmo_err", err_o, 1'b1);
    chk("tmo_busy", busy_o, 1'b0);
    chk("tmo_polls", cnt_acc(1'b0, 22'h00), 1024);
    chk("tmo_wr00", cnt_acc(1'b1, 22'h00), 1);
    chk("tmo_wr10", cnt_acc(1'b1, 22'h10), 0);
    chk("tmo_wr14", cnt_acc(1'b1, 22'h14), 0);
    chk("tmo_done", n_done - d0, 0);

    // Bus error on the gt read (sq read when the offset loop is absent)
    done_on = 1; inj_err = 1'b1; err_adr = OFF_EN ? 22'h08 : 22'h04; log_q.delete();
    pulse_start();
    chk("berr_err_clr", err_o, 1'b0);
    k = 0;
    while (!wb_err_i && k < 500) begin @(posedge wb_clk_i); k++; end
    chk("berr_seen", wb_err_i, 1'b1);
    @(negedge wb_clk_i);
    chk("berr_cyc", wb_cyc_o, 1'b0);
    chk("berr_stb", wb_stb_o, 1'b0);
    chk("berr_err", err_o, 1'b1);
    chk("berr_busy", busy_o, 1'b0);
    chk("berr_wr10", cnt_acc(1'b1, 22'h10), 0);
    inj_err = 1'b0;
    run_iter("berr_rec");
    chk("berr_rec_err", err_o, 1'b0);

    // Continuous over three iterations, with starts while busy and in DONE
    tgt_sq = 24'h400000; tgt_gt = 21'd10; tgt_lt = 21'd10;
    log_q.delete(); d0 = n_done;
    run_cont("cont3", 3);
    chk("cont3_done_cnt", n_done - d0, 3);
    chk("cont3_wr00", cnt_acc(1'b1, 22'h00), 6);
    chk("cont3_ctrl", last_wr(22'h00), CTRL_EXP);
    chk("cont3_rd08", cnt_acc(1'b0, 22'h08), OFF_EN ? 3 : 0);
    chk("cont3_rd0c", cnt_acc(1'b0, 22'h0C), OFF_EN ? 3 : 0);
    chk("cont3_wr14", cnt_acc(1'b1, 22'h14), OFF_EN ? 3 : 0);

    // Reset mid-transaction drops the bus immediately
    done_on = 0;
    pulse_start();
    k = 0;
    while (!wb_cyc_o && k < 100) begin @(negedge wb_clk_i); k++; end
    chk("mrst_cyc_before", wb_cyc_o, 1'b1);
    #2 wb_rstn_i = 1'b0;
    #1;
    chk("mrst_cyc", wb_cyc_o, 1'b0);
    chk("mrst_busy", busy_o, 1'b0);
    chk("mrst_scale", scale_o, 17'h10000);
    @(negedge wb_clk_i); wb_rstn_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    chk("mrst_idle", busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
